// File: rtl/activity_requester_if.sv
// Activity request bundle between navigation, the activity counters and the
// requester. The requester takes the master modport; the surrounding logic
// (navigation plus hunger/sleep counters) takes the slave modport.
interface activity_requester_if;
  logic       transition;
  logic [3:0] activity;
  logic       doneEat;
  logic       doneSleep;
  logic       startEat;
  logic       startSleep;
  logic       busy;
  logic       timeout;
  logic [7:0] completed;

  modport master (
    input  transition, activity, doneEat, doneSleep,
    output startEat, startSleep, busy, timeout, completed
  );

  modport slave (
    output transition, activity, doneEat, doneSleep,
    input  startEat, startSleep, busy, timeout, completed
  );
endinterface

// File: rtl/activity_requester.sv
// Activity requester: initiator side of a four-phase start/done handshake
// towards the hunger and sleep counters. It holds one pending request that
// arrives while busy, where the newest request wins.
// Optional feature macro: ACTIVITY_REQ_TIMEOUT_EN. When it is defined, a
// request that is not answered within TIMEOUT_CYCLES cycles is aborted with
// a one-cycle timeout pulse. When it is undefined, a request waits
// indefinitely and timeout is tied low.
//
// state     | meaning
// IDLE      | no request outstanding, a new or pending request may launch
// REQ_EAT   | startEat high, waiting for doneEat
// REQ_SLEEP | startSleep high, waiting for doneSleep
// COOLDOWN  | start dropped, waiting for both done levels to return low
module activity_requester #(
  parameter logic [3:0]  EAT_CODE       = 4'd1,
  parameter logic [3:0]  SLEEP_CODE     = 4'd2,
  parameter logic [25:0] TIMEOUT_CYCLES = 26'd50_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  activity_requester_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ_EAT   = 2'd1,
    REQ_SLEEP = 2'd2,
    COOLDOWN  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       start_eat_q, start_eat_d;
  logic       start_sleep_q, start_sleep_d;
  logic [7:0] completed_q, completed_d;
  logic       pend_valid_q, pend_valid_d;
  logic       pend_sleep_q, pend_sleep_d;

  logic       is_eat, is_sleep, code_valid, launch_sleep;
  logic [7:0] completed_inc;

`ifdef ACTIVITY_REQ_TIMEOUT_EN
  localparam logic [25:0] TMR_LAST = TIMEOUT_CYCLES - 26'd1;
  logic [25:0] tmr_q, tmr_d;
  logic        timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  assign is_eat        = bus.transition && (bus.activity == EAT_CODE);
  assign is_sleep      = bus.transition && (bus.activity == SLEEP_CODE);
  assign code_valid    = is_eat || is_sleep;
  // A fresh request in the same cycle beats the stored one.
  assign launch_sleep  = code_valid ? is_sleep : pend_sleep_q;
  assign completed_inc = (completed_q == 8'hFF) ? completed_q : completed_q + 8'd1;

  // Next-state and next-output computation for the handshake FSM.
  always_comb begin
    state_d       = state_q;
    start_eat_d   = start_eat_q;
    start_sleep_d = start_sleep_q;
    completed_d   = completed_q;
    pend_valid_d  = pend_valid_q;
    pend_sleep_d  = pend_sleep_q;
`ifdef ACTIVITY_REQ_TIMEOUT_EN
    tmr_d         = tmr_q;
    timeout_d     = 1'b0;
`endif

    // Any valid code seen while busy, including the COOLDOWN exit cycle,
    // replaces the pending entry.
    if ((state_q != IDLE) && code_valid) begin
      pend_valid_d = 1'b1;
      pend_sleep_d = is_sleep;
    end

    unique case (state_q)
      IDLE: begin
        if (code_valid || pend_valid_q) begin
          pend_valid_d = 1'b0;
`ifdef ACTIVITY_REQ_TIMEOUT_EN
          tmr_d        = 26'd0;
`endif
          if (launch_sleep) begin
            state_d       = REQ_SLEEP;
            start_sleep_d = 1'b1;
          end else begin
            state_d     = REQ_EAT;
            start_eat_d = 1'b1;
          end
        end
      end

      REQ_EAT: begin
        if (bus.doneEat) begin
          start_eat_d = 1'b0;
          state_d     = COOLDOWN;
          completed_d = completed_inc;
        end
`ifdef ACTIVITY_REQ_TIMEOUT_EN
        else if (tmr_q == TMR_LAST) begin
          start_eat_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = COOLDOWN;
        end else begin
          tmr_d = tmr_q + 26'd1;
        end
`endif
      end

      REQ_SLEEP: begin
        if (bus.doneSleep) begin
          start_sleep_d = 1'b0;
          state_d       = COOLDOWN;
          completed_d   = completed_inc;
        end
`ifdef ACTIVITY_REQ_TIMEOUT_EN
        else if (tmr_q == TMR_LAST) begin
          start_sleep_d = 1'b0;
          timeout_d     = 1'b1;
          state_d       = COOLDOWN;
        end else begin
          tmr_d = tmr_q + 26'd1;
        end
`endif
      end

      COOLDOWN: begin
        if (!bus.doneEat && !bus.doneSleep) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d       = IDLE;
        start_eat_d   = 1'b0;
        start_sleep_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any start level at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      start_eat_q   <= 1'b0;
      start_sleep_q <= 1'b0;
      completed_q   <= 8'd0;
      pend_valid_q  <= 1'b0;
      pend_sleep_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_eat_q   <= start_eat_d;
      start_sleep_q <= start_sleep_d;
      completed_q   <= completed_d;
      pend_valid_q  <= pend_valid_d;
      pend_sleep_q  <= pend_sleep_d;
    end
  end

`ifdef ACTIVITY_REQ_TIMEOUT_EN
  // Request hold timer and the abort pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q     <= 26'd0;
      timeout_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.startEat   = start_eat_q;
  assign bus.startSleep = start_sleep_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.completed  = completed_q;

endmodule

// File: tb/tb_activity_requester.sv
// Self-checking bench for activity_requester with TIMEOUT_CYCLES=16.
// Expected outputs come from a request-level model: which request is
// outstanding, how many cycles it has been held, whether the counters are
// still settling, the newest pending code and a saturating completion count.
module tb_activity_requester;

  localparam int TO_CYC = 16;
`ifdef ACTIVITY_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  activity_requester_if bus ();

  activity_requester #(
    .EAT_CODE       (4'd1),
    .SLEEP_CODE     (4'd2),
    .TIMEOUT_CYCLES (26'd16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: m_req 0=none 1=eat 2=sleep; m_settle=waiting for done levels low.
  int m_req, m_held, m_pend, m_done_cnt;
  bit m_settle, m_to;

  logic [11:0] obs, expv;
  assign obs = {bus.startEat, bus.startSleep, bus.busy, bus.timeout, bus.completed};

  function automatic void mreset();
    m_req = 0; m_held = 0; m_pend = 0; m_done_cnt = 0; m_settle = 0; m_to = 0;
  endfunction

  function automatic logic [11:0] mexp();
    logic [7:0] c;
    c = 8'(m_done_cnt);
    return {m_req == 1, m_req == 2, (m_req != 0) || m_settle, m_to, c};
  endfunction

  // Advance one clock with the given inputs and move the model along.
  task automatic cyc(input bit tr, input logic [3:0] act, input bit de, input bit ds);
    bit valid, done;
    bus.transition = tr; bus.activity = act; bus.doneEat = de; bus.doneSleep = ds;
    @(posedge clk);
    valid = tr && (act == 4'd1 || act == 4'd2);
    m_to = 0;
    if (m_req == 0 && !m_settle) begin
      if (valid) begin
        m_req = int'(act); m_pend = 0; m_held = 1;
      end else if (m_pend != 0) begin
        m_req = m_pend; m_pend = 0; m_held = 1;
      end
    end else begin
      if (valid) m_pend = int'(act);
      if (m_req != 0) begin
        done = (m_req == 1) ? de : ds;
        if (done) begin
          m_done_cnt = (m_done_cnt >= 255) ? 255 : m_done_cnt + 1;
          m_req = 0; m_settle = 1;
        end else if (TO_EN && m_held == TO_CYC) begin
          m_to = 1; m_req = 0; m_settle = 1;
        end else begin
          m_held++;
        end
      end else if (!de && !ds) begin
        m_settle = 0;
      end
    end
    expv = mexp();
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (bus.startEat && bus.startSleep) begin
        n_fail++;
        $display("FAIL exclusive_start: startEat=%b startSleep=%b required not both 1", bus.startEat, bus.startSleep);
      end
    end
  end

  task automatic test_reset();
    bus.transition = 0; bus.activity = 0; bus.doneEat = 0; bus.doneSleep = 0;
    reset = 1'b1;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", obs, 12'h000);
    end
    reset = 1'b0;
    cyc(1, 4'd1, 0, 0);
    n_cmp++;
    if (bus.startEat !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_after_reset: startEat=%b busy=%b required 1 1", bus.startEat, bus.busy);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL reset_followup: got %h required %h", obs, expv);
    end
  endtask

  task automatic test_eat_handshake();
    int c0;
    c0 = m_done_cnt;
    cyc(1, 4'd1, 0, 0);
    n_cmp++;
    if (bus.startEat !== 1'b1 || bus.busy !== 1'b1 || bus.startSleep !== 1'b0) begin
      n_fail++;
      $display("FAIL eat_start: startEat=%b busy=%b startSleep=%b required 1 1 0", bus.startEat, bus.busy, bus.startSleep);
    end
    repeat (3) cyc(0, 0, 0, 1);
    n_cmp++;
    if (obs !== expv || bus.startEat !== 1'b1) begin
      n_fail++;
      $display("FAIL eat_ignores_doneSleep: got %h required %h", obs, expv);
    end
    cyc(0, 0, 1, 0);
    n_cmp++;
    if (bus.startEat !== 1'b0 || bus.completed !== 8'(c0 + 1) || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL eat_done: startEat=%b completed=%0d busy=%b required 0 %0d 1", bus.startEat, bus.completed, bus.busy, c0 + 1);
    end
    cyc(0, 0, 1, 0);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cooldown_hold: busy=%b required 1", bus.busy);
    end
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (bus.busy !== 1'b0 || obs !== expv) begin
      n_fail++;
      $display("FAIL cooldown_exit: got %h required %h", obs, expv);
    end
  endtask

  task automatic test_pending();
    cyc(1, 4'd7, 0, 0);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.startEat !== 1'b0 || bus.startSleep !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_code: busy=%b startEat=%b startSleep=%b required 0 0 0", bus.busy, bus.startEat, bus.startSleep);
    end
    cyc(1, 4'd1, 0, 0);
    cyc(1, 4'd2, 0, 0);
    cyc(1, 4'd1, 0, 0);
    cyc(1, 4'd9, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_idle_gap: busy=%b required 0", bus.busy);
    end
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (bus.startEat !== 1'b1 || bus.startSleep !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_newest_wins: startEat=%b startSleep=%b required 1 0", bus.startEat, bus.startSleep);
    end
    cyc(0, 0, 1, 0);
    cyc(1, 4'd2, 0, 0);
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (bus.startSleep !== 1'b1 || obs !== expv) begin
      n_fail++;
      $display("FAIL pend_on_cooldown_exit: got %h required %h", obs, expv);
    end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (bus.busy !== 1'b0 || obs !== expv) begin
      n_fail++;
      $display("FAIL pend_cleared: got %h required %h", obs, expv);
    end
  endtask

  task automatic test_timeout();
    int c0, high, pulses;
    c0 = m_done_cnt; high = 0; pulses = 0;
    cyc(1, 4'd2, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if (bus.startSleep) high++;
      if (bus.timeout) pulses++;
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL timeout_trace cycle %0d: got %h required %h", i, obs, expv);
      end
      cyc(0, 0, 0, 0);
    end
    n_cmp++;
    if (high !== TO_CYC || pulses !== 1 || bus.completed !== 8'(c0)) begin
      n_fail++;
      $display("FAIL timeout_abort: held=%0d pulses=%0d completed=%0d required %0d 1 %0d", high, pulses, bus.completed, TO_CYC, c0);
    end
    cyc(1, 4'd2, 0, 0);
    repeat (TO_CYC - 1) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    n_cmp++;
    if (bus.timeout !== 1'b0 || bus.completed !== 8'(c0 + 1) || bus.startSleep !== 1'b0) begin
      n_fail++;
      $display("FAIL done_wins_last: timeout=%b completed=%0d startSleep=%b required 0 %0d 0", bus.timeout, bus.completed, bus.startSleep, c0 + 1);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_no_timeout_hold();
    int bad;
    bad = 0;
    cyc(1, 4'd1, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      cyc(0, 0, 0, 0);
      if (bus.timeout !== 1'b0 || bus.startEat !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_no_timeout: %0d bad cycles required 0", bad);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit tr, de, ds;
    logic [3:0] act;
    for (int i = 0; i < 3000; i++) begin
      tr  = ($urandom_range(0, 3) == 0);
      act = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) act = 4'd7;
      de  = ($urandom_range(0, 4) == 0);
      ds  = ($urandom_range(0, 4) == 0);
      cyc(tr, act, de, ds);
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h required %h", i, obs, expv);
      end
    end
    repeat (4) cyc(0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    int bad;
    bad = 0;
    for (int i = 0; i < 257; i++) begin
      cyc(1, 4'd1, 0, 0);
      if (obs !== expv) bad++;
      cyc(0, 0, 1, 0);
      if (obs !== expv) bad++;
      cyc(0, 0, 0, 0);
      if (obs !== expv) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL saturation_trace: %0d bad cycles required 0", bad);
    end
    n_cmp++;
    if (bus.completed !== 8'd255) begin
      n_fail++;
      $display("FAIL saturation: completed=%0d required 255", bus.completed);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 4'd1, 0, 0);
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (bus.startEat !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_setup: startEat=%b required 1", bus.startEat);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.startEat !== 1'b0 || bus.busy !== 1'b0 || bus.completed !== 8'd0 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: startEat=%b busy=%b completed=%0d timeout=%b required 0 0 0 0", bus.startEat, bus.busy, bus.completed, bus.timeout);
    end
    mreset();
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_after: got %h required %h", obs, 12'h000);
    end
  endtask

  initial begin
    test_reset();
    test_eat_handshake();
    test_pending();
`ifdef ACTIVITY_REQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout_hold();
`endif
    test_random();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
